vx_div_sequencer: RTL

//  Shares one multi-cycle serial divider (strobe/busy contract) between NUM_REQS requesters.
//  - Arbitrates round-robin and latches the winner's operands and tag.
//  - Pulses the divider strobe, waits for completion, and returns a registered response

---
 rtl/vx_div_seq_pkg.sv | 21 ++
 rtl/vx_div_sequencer_if.sv | 59 +++++
 rtl/vx_rr_grant.sv | 39 +++
 rtl/vx_div_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/vx_div_seq_pkg.sv
// Shared types and helpers for the divider sequencer.
//   state_e   : sequencer FSM states
//   log2up()  : index width for a requester count, never below 1 bit
//   REQ_ID_W  : requester-id width for the default four-requester configuration
package vx_div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_REQS_DEF = 4;
  localparam int REQ_ID_W     = log2up(NUM_REQS_DEF);

endpackage

// File: rtl/vx_div_sequencer_if.sv
// Bundle of every signal between the divider sequencer and its neighbours:
// the requester issue ports, the shared serial divider and the response port.
//   master : the environment (requesters, divider, response consumer)
//   slave  : the sequencer itself
interface vx_div_sequencer_if
  import vx_div_seq_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int LANES     = 1,
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 8
);
  localparam int ID_W = log2up(NUM_REQS);
  localparam int LW   = LANES * WIDTH;

  // requester side
  logic [NUM_REQS-1:0]           req_valid;
  logic [NUM_REQS-1:0]           req_ready;
  logic [NUM_REQS*LW-1:0]        req_numer;
  logic [NUM_REQS*LW-1:0]        req_denom;
  logic [NUM_REQS-1:0]           req_signed;
  logic [NUM_REQS-1:0]           req_is_rem;
  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag;

  // divider side
  logic          div_strobe;
  logic          div_busy;
  logic [LW-1:0] div_numer;
  logic [LW-1:0] div_denom;
  logic          div_signed;
  logic [LW-1:0] div_quot;
  logic [LW-1:0] div_rem;

  // response side
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [LW-1:0]        rsp_data;
  logic [TAG_WIDTH-1:0] rsp_tag;
  logic [ID_W-1:0]      rsp_req_id;

  modport master (
    output req_valid, req_numer, req_denom, req_signed, req_is_rem, req_tag,
    input  req_ready,
    input  div_strobe, div_numer, div_denom, div_signed,
    output div_busy, div_quot, div_rem,
    input  rsp_valid, rsp_data, rsp_tag, rsp_req_id,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_numer, req_denom, req_signed, req_is_rem, req_tag,
    output req_ready,
    output div_strobe, div_numer, div_denom, div_signed,
    input  div_busy, div_quot, div_rem,
    output rsp_valid, rsp_data, rsp_tag, rsp_req_id,
    input  rsp_ready
  );

endinterface

// File: rtl/vx_rr_grant.sv
// Combinational round-robin picker: selects the first valid requester at or
// after ptr_i, wrapping around.
//   valid_i : request valid per requester
//   ptr_i   : highest-priority requester index this cycle
//   grant_o : one-hot winner (all zero when nothing is valid)
//   any_o   : at least one requester is valid
//   idx_o   : binary index of the winner
module vx_rr_grant
  import vx_div_seq_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int ID_W     = log2up(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] valid_i,
  input  logic [ID_W-1:0]     ptr_i,
  output logic [NUM_REQS-1:0] grant_o,
  output logic                any_o,
  output logic [ID_W-1:0]     idx_o
);

  // NOTE: every output gets a default before the search loop so no path
  // leaves a value unassigned, which would infer a latch.
  always_comb begin
    int k;
    grant_o = '0;
    any_o   = 1'b0;
    idx_o   = '0;
    k       = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      k = (int'(ptr_i) + i) % NUM_REQS;
      if (!any_o && valid_i[k]) begin
        any_o      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/vx_div_sequencer.sv
// Shares one multi-cycle serial divider between NUM_REQS requesters.
// Round-robin arbitration, operand latching, one-cycle divider strobe,
// completion wait, and a registered, tagged response with backpressure.
// A zero denominator on every lane bypasses the divider (RISC-V results).
//   clk   : clock
//   reset : asynchronous, active-low reset
//   bus   : slave view of vx_div_sequencer_if (requesters, divider, response)
module vx_div_sequencer
  import vx_div_seq_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int LANES     = 1,
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  vx_div_sequencer_if.slave  bus
);

  localparam int ID_W = log2up(NUM_REQS);
  localparam int LW   = LANES * WIDTH;

  state_e               state_q;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [LW-1:0]        numer_q;
  logic [LW-1:0]        denom_q;
  logic                 signed_q;
  logic                 is_rem_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [ID_W-1:0]      req_id_q;
  logic                 strobe_q;
  logic                 wait_first_q;
  logic                 rsp_valid_q;
  logic [LW-1:0]        rsp_data_q;

  logic [NUM_REQS-1:0]  pick;
  logic                 pick_any;
  logic [ID_W-1:0]      pick_idx;
  logic                 grant_en;
  logic [LW-1:0]        sel_numer;
  logic [LW-1:0]        sel_denom;
  logic                 sel_signed;
  logic                 sel_is_rem;
  logic [TAG_WIDTH-1:0] sel_tag;

  vx_rr_grant #(
    .NUM_REQS (NUM_REQS),
    .ID_W     (ID_W)
  ) u_rr_grant (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick),
    .any_o   (pick_any),
    .idx_o   (pick_idx)
  );

  // A new request may be accepted from IDLE, or from RESP in the very cycle
  // the pending response fires. Gating with reset keeps req_ready low while
  // reset is held, so nothing can be accepted that would be thrown away.
  assign grant_en      = reset && ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));
  assign bus.req_ready = grant_en ? pick : '0;

  // One-hot AND-OR select of the winning requester's payload.
  always_comb begin
    sel_numer  = '0;
    sel_denom  = '0;
    sel_signed = 1'b0;
    sel_is_rem = 1'b0;
    sel_tag    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (pick[i]) begin
        sel_numer  = bus.req_numer[i*LW +: LW];
        sel_denom  = bus.req_denom[i*LW +: LW];
        sel_signed = bus.req_signed[i];
        sel_is_rem = bus.req_is_rem[i];
        sel_tag    = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      numer_q      <= '0;
      denom_q      <= '0;
      signed_q     <= 1'b0;
      is_rem_q     <= 1'b0;
      tag_q        <= '0;
      req_id_q     <= '0;
      strobe_q     <= 1'b0;
      wait_first_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      strobe_q <= 1'b0;
      unique case (state_q)
        IDLE, RESP: begin
          if (grant_en) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
            if (pick_any) begin
              numer_q  <= sel_numer;
              denom_q  <= sel_denom;
              signed_q <= sel_signed;
              is_rem_q <= sel_is_rem;
              tag_q    <= sel_tag;
              req_id_q <= pick_idx;
              rr_ptr_q <= ID_W'((int'(pick_idx) + 1) % NUM_REQS);
              if (sel_denom == '0) begin
                // Every lane divides by zero: quotient all ones, remainder = numerator.
                rsp_data_q  <= sel_is_rem ? sel_numer : '1;
                rsp_valid_q <= 1'b1;
                state_q     <= RESP;
              end else begin
                strobe_q <= 1'b1;
                state_q  <= START;
              end
            end
          end
        end
        START: begin
          wait_first_q <= 1'b1;
          state_q      <= WAIT;
        end
        WAIT: begin
          // busy may still be rising in the first WAIT cycle, so it is not trusted.
          if (wait_first_q) begin
            wait_first_q <= 1'b0;
          end else if (!bus.div_busy) begin
            rsp_data_q  <= is_rem_q ? bus.div_rem : bus.div_quot;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.div_strobe = strobe_q;
  assign bus.div_numer  = numer_q;
  assign bus.div_denom  = denom_q;
  assign bus.div_signed = signed_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_tag    = tag_q;
  assign bus.rsp_req_id = req_id_q;

endmodule
